// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if
//   Bundles the memory-stage result, multiplier result and register-file
//   write-port signals that pass between the producer side and the arbiter.
//   Ports (as signals of the interface):
//     mem_valid/mem_we/mem_rd/mem_data : memory-stage result
//     mul_valid/mul_rd/mul_data        : multiplier result
//     stall_mul                        : back-pressure to the multiplier
//     wb_valid/wb_rd/wb_data/wb_src    : registered register-file write port
//     busy_mask                        : registers with buffered mul writes
//     fifo_count                       : multiplier FIFO occupancy
//   Modports: master = result producers, slave = arbiter.
interface wb_port_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic                     mem_valid;
  logic                     mem_we;
  logic [4:0]               mem_rd;
  logic [XLEN-1:0]          mem_data;
  logic                     mul_valid;
  logic [4:0]               mul_rd;
  logic [XLEN-1:0]          mul_data;
  logic                     stall_mul;
  logic                     wb_valid;
  logic [4:0]               wb_rd;
  logic [XLEN-1:0]          wb_data;
  logic                     wb_src;
  logic [31:0]              busy_mask;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport master (
    output mem_valid, mem_we, mem_rd, mem_data,
    output mul_valid, mul_rd, mul_data,
    input  stall_mul, wb_valid, wb_rd, wb_data, wb_src, busy_mask, fifo_count
  );

  modport slave (
    input  mem_valid, mem_we, mem_rd, mem_data,
    input  mul_valid, mul_rd, mul_data,
    output stall_mul, wb_valid, wb_rd, wb_data, wb_src, busy_mask, fifo_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Owns the single register-file write port. Memory-stage results always
//   win; multiplier results that lose are buffered in a DEPTH-entry FIFO and
//   drained in arrival order. The multiplier is stalled while the FIFO is full.
//   Ports:
//     clk  : clock
//     rst  : synchronous reset, active low
//     bus  : wb_port_arbiter_if.slave (result inputs, write port, busy_mask,
//            fifo_count, stall_mul)
module wb_port_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  wb_port_arbiter_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [4:0]      fifo_rd_q   [DEPTH];
  logic [XLEN-1:0] fifo_data_q [DEPTH];

  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            wb_src_q, wb_src_d;
  logic [31:0]     busy_q, busy_d;

  logic            stall;
  logic            mem_req;
  logic            mul_req;
  logic            fifo_empty;
  logic            pop;
  logic            bypass;
  logic            push;
  logic [PW-1:0]   offs;
  logic [4:0]      slot_rd;

  always_comb begin
    stall      = (count_q == CW'(DEPTH));
    mem_req    = bus.mem_valid && bus.mem_we && (bus.mem_rd != 5'd0);
    // x0 and rejected (stalled) multiplier results never become requests.
    mul_req    = bus.mul_valid && !stall && (bus.mul_rd != 5'd0);
    fifo_empty = (count_q == '0);
    pop        = !mem_req && !fifo_empty;
    bypass     = !mem_req && fifo_empty && mul_req;
    push       = mul_req && !bypass;

    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_src_d   = wb_src_q;

    if (mem_req) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = bus.mem_rd;
      wb_data_d  = bus.mem_data;
      wb_src_d   = 1'b0;
    end else if (!fifo_empty) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = fifo_rd_q[rd_ptr_q];
      wb_data_d  = fifo_data_q[rd_ptr_q];
      wb_src_d   = 1'b1;
    end else if (mul_req) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = bus.mul_rd;
      wb_data_d  = bus.mul_data;
      wb_src_d   = 1'b1;
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);

    // Busy mask reflects FIFO contents after this cycle's push/pop: a slot is
    // live when its distance from the new read pointer is below the new count.
    busy_d  = '0;
    offs    = '0;
    slot_rd = '0;
    for (int j = 0; j < DEPTH; j++) begin
      offs    = PW'(j) - rd_ptr_d;
      slot_rd = (push && (wr_ptr_q == PW'(j))) ? bus.mul_rd : fifo_rd_q[j];
      if ({1'b0, offs} < count_d) begin
        busy_d[slot_rd] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_src_q   <= 1'b0;
      busy_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_src_q   <= wb_src_d;
      busy_q     <= busy_d;
    end
  end

  // Storage needs no reset: occupancy is tracked solely by the pointers/count.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      fifo_rd_q[wr_ptr_q]   <= bus.mul_rd;
      fifo_data_q[wr_ptr_q] <= bus.mul_data;
    end
  end

  assign bus.stall_mul  = stall;
  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_rd      = wb_rd_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.wb_src     = wb_src_q;
  assign bus.busy_mask  = busy_q;
  assign bus.fifo_count = count_q;

  a_mem_not_busy: assert property (@(posedge clk) disable iff (!rst)
    mem_req |-> !busy_q[bus.mem_rd]);
  a_count_range: assert property (@(posedge clk) disable iff (!rst)
    count_q <= CW'(DEPTH));
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
    !(push && stall));
  a_mul_held: assert property (@(posedge clk) disable iff (!rst)
    (stall && bus.mul_valid) |=> (bus.mul_valid && $stable(bus.mul_rd) && $stable(bus.mul_data)));
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the single register-file write port.
- Arbitrates between memory-stage results (in-order main pipe) and pipelined-multiplier results.
- Mem results always win. Multiplier results that lose are held in a DEPTH-entry FIFO, and the multiplier is back-pressured when the FIFO is full.
- Exports a busy mask of registers with buffered multiplier writes so decode can stall RAW/WAW hazards against them.

Parameters:
- XLEN, 32, data width.
- DEPTH, 4, multiplier result FIFO entries (power of 2, >=2).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active low
- mem_valid  input  1  memory stage presents a result this cycle
- mem_we  input  1  result writes the register file
- mem_rd  input  5  destination register
- mem_data  input  XLEN  write data
- mul_valid  input  1  multiplier presents a result (held while stall_mul=1)
- mul_rd  input  5  destination register
- mul_data  input  XLEN  write data
- stall_mul  output  1  multiplier must hold its output stage
- wb_valid  output  1  register-file write enable (registered)
- wb_rd  output  5  write address (registered)
- wb_data  output  XLEN  write data (registered)
- wb_src  output  1  0 = mem, 1 = mul (registered)
- busy_mask  output  32  bit r set = buffered mul write to xr pending (registered)
- fifo_count  output  $clog2(DEPTH)+1  FIFO occupancy (registered)

Behaviour:
- Reset (rst==0 at posedge):
  - wb_valid, wb_rd, wb_data, wb_src, busy_mask, fifo_count, read/write pointers all go to 0.
  - Reset mid-operation discards buffered results.
- stall_mul is combinational: (fifo_count == DEPTH). mul_valid is accepted iff mul_valid & !stall_mul.
- Effective requests: mem_req = mem_valid & mem_we & (mem_rd != 0); mul_req = accepted mul & (mul_rd != 0).
  - Non-writing or x0 results are consumed and dropped; they never occupy the port or the FIFO.
- Port selection for cycle t+1, in priority order:
  1. mem_req: wb <= mem, wb_src=0.
  2. FIFO non-empty: wb <= FIFO head, pop, wb_src=1.
  3. FIFO empty & mul_req: wb <= mul input directly (bypass, no push), wb_src=1.
  4. Otherwise wb_valid <= 0; wb_rd/wb_data hold their last value.
- FIFO push: mul_req not taken by the bypass (rule 3) is pushed the same cycle.
  - Push and pop in the same cycle is allowed; count is unchanged.
  - Push is impossible when full, because stall_mul blocks acceptance.
- Ordering: multiplier results leave in arrival order (FIFO); mem results may overtake buffered mul results.
- Pointers wrap modulo DEPTH; count range 0..DEPTH.
- busy_mask: registered OR of one-hot(rd) over valid FIFO entries after this cycle's push/pop. Decode must stall any instruction whose rs1/rs2/rd hits a set bit.
- Latency: 1 cycle from input to wb_* when a result wins the port; unbounded while mem_req is continuously asserted.
- Assertions:
  - mem_req with mem_rd set in busy_mask never occurs (decode guarantees).
  - fifo_count <= DEPTH.
  - No push when full.
  - mul_valid held stable while stall_mul=1.

Test Plan:
- Reset: drive rst=0 for 2 cycles with mem/mul traffic -> all outputs 0, stall_mul=0. Release -> mem_valid,we,rd=5,data=0xAA -> next cycle wb_valid=1, rd=5, data=0xAA, src=0.
- Bypass: FIFO empty, mul_valid rd=7 data=0x1234, no mem -> next cycle wb rd=7, data=0x1234, src=1; fifo_count stays 0, busy_mask=0.
- Collision: same cycle mem rd=3 and mul rd=9 -> t+1 wb rd=3 src=0, fifo_count=1, busy_mask=0x200; t+2 (idle) wb rd=9 src=1, count=0, busy_mask=0.
- Full/back-pressure (DEPTH=4): mem_req every cycle for 6 cycles, mul_valid every cycle rd=10..13 then rd=14 held -> count reaches 4, stall_mul=1, rd=14 not accepted. Drop mem -> pops 10,11,12,13 in order; stall_mul deasserts after first pop, then 14 is accepted and written after 13.
- Drops: mem_valid with mem_we=0, and mul rd=0 -> wb_valid stays 0, no FIFO push; simultaneous buffered head is drained in that slot.
- Reset mid-operation: FIFO holding 3 entries, assert rst -> count=0, busy_mask=0, no further wb of stale entries.
